// File: rtl/pll_dynphase_ctrl.sv
// Dynamic-phase sequencer for the ECP5 EHXPLLL: drives PHASESEL/PHASEDIR/PHASESTEP,
// tracks per-channel phase position and qualifies PLL lock with a stability timer.
module pll_dynphase_ctrl #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 8,
    parameter int POS_W        = 10,
    parameter int SETUP_CYCLES = 2,
    parameter int STEP_LOW     = 2,
    parameter int STEP_GAP     = 4,
    parameter int LOCK_STABLE  = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      pll_locked,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_chan,
    input  logic [CNT_W-1:0]          req_steps,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                phasesel,
    output logic                      phasedir,
    output logic                      phasestep,
    output logic                      phaseloadreg,
    output logic [CHANNELS*POS_W-1:0] pos,
    output logic                      locked_stable,
    output logic                      lock_lost,
    input  logic                      lock_lost_clr
);

    typedef enum logic [2:0] {IDLE, SETUP, STEP_LO, STEP_HI, FIN} state_t;

    localparam int TW = $clog2(LOCK_STABLE + 1);
    localparam logic [TW-1:0] LS_MAX = TW'(LOCK_STABLE);
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] LOW_LAST   = 8'(STEP_LOW - 1);
    localparam logic [7:0] GAP_LAST   = 8'(STEP_GAP - 1);

    state_t           state, state_n;
    logic             lk_s1, lk_s2;
    logic [TW-1:0]    timer;
    logic [7:0]       cnt;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] mag;
    logic             err_r;
    logic             accept;
    logic             chan_ok;
    logic [POS_W-1:0] pos_r [CHANNELS];

    // Two's-complement negation of the most negative value yields 2^(CNT_W-1) as unsigned.
    assign mag          = req_steps[CNT_W-1] ? ('0 - req_steps) : req_steps;
    assign chan_ok      = int'(req_chan) < CHANNELS;
    assign accept       = req_valid & req_ready;
    assign phaseloadreg = 1'b1;

    always_comb begin
        state_n       = state;
        locked_stable = (timer == LS_MAX);
        req_ready     = (state == IDLE) & locked_stable;
        busy          = (state == SETUP) | (state == STEP_LO) | (state == STEP_HI);
        done          = (state == FIN);
        err           = (state == FIN) & err_r;
        phasestep     = (state != STEP_LO);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!chan_ok || req_steps == '0) state_n = FIN;
                    else                             state_n = SETUP;
                end
            end
            SETUP: begin
                if (!locked_stable)          state_n = FIN;
                else if (cnt == SETUP_LAST)  state_n = STEP_LO;
            end
            STEP_LO: begin
                if (!locked_stable)          state_n = FIN;
                else if (cnt == LOW_LAST)    state_n = STEP_HI;
            end
            STEP_HI: begin
                if (!locked_stable)          state_n = FIN;
                else if (cnt == GAP_LAST)    state_n = (rem != '0) ? STEP_LO : FIN;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            lk_s1     <= 1'b0;
            lk_s2     <= 1'b0;
            timer     <= '0;
            lock_lost <= 1'b0;
            cnt       <= '0;
            rem       <= '0;
            err_r     <= 1'b0;
            phasesel  <= '0;
            phasedir  <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) pos_r[i] <= '0;
        end else begin
            lk_s1 <= pll_locked;
            lk_s2 <= lk_s1;
            if (!lk_s2)               timer <= '0;
            else if (timer != LS_MAX) timer <= timer + TW'(1);

            // A full timer with the synchronised lock low is exactly a qualified-lock drop.
            if (!lk_s2 && timer == LS_MAX) lock_lost <= 1'b1;
            else if (lock_lost_clr)        lock_lost <= 1'b0;

            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 8'd1;

            if (state == IDLE && accept) begin
                err_r <= !chan_ok;
                if (chan_ok && req_steps != '0) begin
                    phasesel <= req_chan;
                    phasedir <= req_steps[CNT_W-1];
                    rem      <= mag;
                end
            end

            if (busy && !locked_stable) err_r <= 1'b1;

            if (state == STEP_LO && state_n == STEP_HI) begin
                rem <= rem - CNT_W'(1);
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    if (phasesel == 2'(i))
                        pos_r[i] <= phasedir ? pos_r[i] - POS_W'(1) : pos_r[i] + POS_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pos
        assign pos[g*POS_W +: POS_W] = pos_r[g];
    end

endmodule

// File: tb/tb_pll_dynphase_ctrl.sv
// Directed bench for pll_dynphase_ctrl: expected completions are queued at request time
// and checked with immediate assertions when done pulses.
module tb_pll_dynphase_ctrl;

    localparam int S   = 2;
    localparam int L   = 2;
    localparam int G   = 4;
    localparam int LS  = 1024;
    localparam int LSB = 8;

    logic        clk = 1'b0;
    logic        rstn, pll_locked, lock_lost_clr;
    logic        req_valid, req_ready, busy, done, err;
    logic [1:0]  req_chan, phasesel;
    logic [7:0]  req_steps;
    logic        phasedir, phasestep, phaseloadreg, locked_stable, lock_lost;
    logic [39:0] pos;

    logic        req_valid_b, req_ready_b, busy_b, done_b, err_b;
    logic [1:0]  req_chan_b, phasesel_b;
    logic [7:0]  req_steps_b;
    logic        phasedir_b, phasestep_b, phaseloadreg_b, locked_stable_b, lock_lost_b;
    logic [19:0] pos_b;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int pulses_a = 0, lows_a = 0, badsd_a = 0, pulses_b = 0;
    int pstart, lstart, ta, n;
    logic prev_a = 1'b1, prev_b = 1'b1;
    logic [1:0] exp_sel;
    logic       exp_dir;

    typedef struct {
        logic       err;
        logic [9:0] pos;
        int         chan;
        int         cyc;
        int         pulses;
    } exp_t;
    exp_t sb[$];

    pll_dynphase_ctrl #(.CHANNELS(4), .LOCK_STABLE(LS)) dut (
        .clk(clk), .rstn(rstn), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan), .req_steps(req_steps),
        .busy(busy), .done(done), .err(err),
        .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
        .pos(pos), .locked_stable(locked_stable), .lock_lost(lock_lost), .lock_lost_clr(lock_lost_clr)
    );

    pll_dynphase_ctrl #(.CHANNELS(2), .LOCK_STABLE(LSB)) dut_b (
        .clk(clk), .rstn(rstn), .pll_locked(pll_locked),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_chan(req_chan_b), .req_steps(req_steps_b),
        .busy(busy_b), .done(done_b), .err(err_b),
        .phasesel(phasesel_b), .phasedir(phasedir_b), .phasestep(phasestep_b), .phaseloadreg(phaseloadreg_b),
        .pos(pos_b), .locked_stable(locked_stable_b), .lock_lost(lock_lost_b), .lock_lost_clr(lock_lost_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!phasestep) begin
            lows_a++;
            if (prev_a) pulses_a++;
            if (phasesel !== exp_sel || phasedir !== exp_dir) badsd_a++;
        end
        prev_a = phasestep;
        if (!phasestep_b && prev_b) pulses_b++;
        prev_b = phasestep_b;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [1:0] ch, input logic [7:0] st, output int t);
        chk("ready_before_req", req_ready, 1);
        pstart    = pulses_a;
        lstart    = lows_a;
        req_chan  = ch;
        req_steps = st;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        t = cyc;
    endtask

    task automatic wait_done_a(input int budget);
        exp_t e;
        int k = 0;
        while (!done && k < budget) begin
            tick;
            k++;
        end
        e = sb.pop_front();
        chk("done_seen", done, 1);
        chk("done_cycle", cyc, e.cyc);
        chk("err", err, e.err);
        chk("pos_chan", pos[e.chan*10 +: 10], e.pos);
        chk("step_pulses", pulses_a - pstart, e.pulses);
        chk("step_low_cycles", lows_a - lstart, e.pulses * L);
        chk("busy_at_done", busy, 0);
        chk("phasestep_at_done", phasestep, 1);
        tick;
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        rstn = 1'b0; pll_locked = 1'b1; lock_lost_clr = 1'b0;
        req_valid = 1'b0; req_chan = '0; req_steps = '0;
        req_valid_b = 1'b0; req_chan_b = '0; req_steps_b = '0;
        exp_sel = '0; exp_dir = 1'b0;
        repeat (4) tick;

        chk("rst_phasestep", phasestep, 1);
        chk("rst_phaseloadreg", phaseloadreg, 1);
        chk("rst_phasedir", phasedir, 0);
        chk("rst_phasesel", phasesel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_pos", pos, 0);
        chk("rst_locked_stable", locked_stable, 0);
        chk("rst_lock_lost", lock_lost, 0);

        // Two synchroniser edges plus LOCK_STABLE timer edges after release.
        rstn = 1'b1;
        n = 0;
        while (!locked_stable && n < 2000) begin
            tick;
            n++;
        end
        chk("lock_rise_cycles", n, LS + 2);
        chk("req_ready_follows_lock", req_ready, 1);

        exp_sel = 2'd1; exp_dir = 1'b0;
        send_a(2'd1, 8'd3, ta);
        chk("r1_phasesel", phasesel, 1);
        chk("r1_phasedir", phasedir, 0);
        chk("r1_busy", busy, 1);
        chk("r1_ready_low_busy", req_ready, 0);
        sb.push_back('{err: 1'b0, pos: 10'd3, chan: 1, cyc: ta + S + 3*(L+G), pulses: 3});
        wait_done_a(100);

        exp_sel = 2'd2; exp_dir = 1'b1;
        send_a(2'd2, 8'h80, ta);
        chk("r2_phasedir", phasedir, 1);
        sb.push_back('{err: 1'b0, pos: 10'd896, chan: 2, cyc: ta + S + 128*(L+G), pulses: 128});
        wait_done_a(1000);

        send_a(2'd0, 8'd0, ta);
        sb.push_back('{err: 1'b0, pos: 10'd0, chan: 0, cyc: ta, pulses: 0});
        wait_done_a(10);

        chk("b_ready", req_ready_b, 1);
        pstart = pulses_b;
        req_chan_b = 2'd3; req_steps_b = 8'd5; req_valid_b = 1'b1;
        tick;
        req_valid_b = 1'b0;
        chk("b_done_bad_chan", done_b, 1);
        chk("b_err_bad_chan", err_b, 1);
        chk("b_pos_unchanged", pos_b, 0);
        tick;
        chk("b_done_one_cycle", done_b, 0);
        chk("b_no_pulses", pulses_b - pstart, 0);

        // Lock drops at the start of the 2nd STEP_LO; the 2nd step still gets counted on STEP_HI entry.
        exp_sel = 2'd0; exp_dir = 1'b0;
        send_a(2'd0, 8'd5, ta);
        repeat (8) tick;
        pll_locked = 1'b0;
        sb.push_back('{err: 1'b1, pos: 10'd2, chan: 0, cyc: ta + 12, pulses: 2});
        wait_done_a(100);
        chk("lost_lock_lost", lock_lost, 1);
        chk("lost_locked_stable", locked_stable, 0);
        repeat (5) tick;
        chk("lost_sticky", lock_lost, 1);
        chk("lost_ready_low", req_ready, 0);
        lock_lost_clr = 1'b1;
        tick;
        lock_lost_clr = 1'b0;
        chk("lost_cleared", lock_lost, 0);
        pll_locked = 1'b1;
        n = 0;
        while (!locked_stable && n < 1100) begin
            tick;
            n++;
        end
        chk("relock", locked_stable, 1);

        exp_sel = 2'd1; exp_dir = 1'b0;
        send_a(2'd1, 8'd2, ta);
        n = 0;
        while (phasestep && n < 20) begin
            tick;
            n++;
        end
        chk("reached_step_lo", phasestep, 0);
        rstn = 1'b0;
        tick;
        chk("rstmid_phasestep", phasestep, 1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_pos", pos, 0);
        chk("rstmid_done", done, 0);
        rstn = 1'b1;
        repeat (4) begin
            tick;
            chk("rstmid_no_done", done, 0);
        end

        chk("sel_dir_stable_low", badsd_a, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
